// File: rtl/vline_motion_ctrl_if.sv
// Link between the vertical line motion controller and the line position
// counter chain: strobes and load data out, current coordinate back in.
interface vline_motion_ctrl_if;
    logic [15:0] ycoord;
    logic        UP;
    logic        DW;
    logic        LD;
    logic [15:0] ld_val;

    // The motion controller drives the strobes and reads the coordinate
    modport master (
        input  ycoord,
        output UP,
        output DW,
        output LD,
        output ld_val
    );

    // The counter chain consumes the strobes and reports the coordinate
    modport slave (
        output ycoord,
        input  UP,
        input  DW,
        input  LD,
        input  ld_val
    );
endinterface

// File: rtl/vline_motion_ctrl.sv
// Vertical line motion controller.
// Turns debounced buttons and the per-frame tick into single-cycle UP/DW/LD
// strobes for the line position counter, and stops or reverses at the
// playfield limits using the coordinate read back from the counter.
// Optional feature macro: VLINE_BOUNCE_EN (reverse at a limit instead of
// stopping).
module vline_motion_ctrl #(
    parameter int Y_MIN    = 18,
    parameter int Y_MAX    = 487,
    parameter int CENTER   = 252,
    parameter int STEP_DIV = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame,
    input  logic                btnU,
    input  logic                btnD,
    input  logic                btnC,
    vline_motion_ctrl_if.master cnt,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INC  = 2'b01,
        DEC  = 2'b10
    } state_t;

    localparam logic [15:0] YMinV   = 16'(Y_MIN);
    localparam logic [15:0] YMaxV   = 16'(Y_MAX);
    localparam logic [15:0] LdValue = 16'(CENTER);
    localparam logic [3:0]  DivLast = 4'(STEP_DIV - 1);

    state_t      cur;
    logic [3:0]  divider;
    logic        upReg;
    logic        dwReg;
    logic        ldReg;

    // Button pipelines, bit order {C, D, U}
    logic [2:0]  btnMeta;
    logic [2:0]  btnSync;
    logic [2:0]  btnPrev;
    logic [2:0]  btnEdge;
    logic        goUp;
    logic        goDown;
    logic        stepTick;

    assign btnEdge  = btnSync & ~btnPrev;
    assign goUp     = btnEdge[0] & ~btnEdge[1];
    assign goDown   = btnEdge[1] & ~btnEdge[0];
    assign stepTick = frame && (divider == DivLast);

    assign cnt.UP     = upReg;
    assign cnt.DW     = dwReg;
    assign cnt.LD     = ldReg;
    assign cnt.ld_val = LdValue;
    assign state      = cur;

    // Bring the asynchronous buttons into the clock domain and keep the
    // previous synchronized level for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btnMeta <= 3'b000;
            btnSync <= 3'b000;
            btnPrev <= 3'b000;
        end else begin
            btnMeta <= {btnC, btnD, btnU};
            btnSync <= btnMeta;
            btnPrev <= btnSync;
        end
    end

    // Motion FSM with frame divider and registered one-cycle strobes;
    // recentre wins over everything, including a coincident step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur     <= IDLE;
            divider <= 4'd0;
            upReg   <= 1'b0;
            dwReg   <= 1'b0;
            ldReg   <= 1'b0;
        end else begin
            upReg <= 1'b0;
            dwReg <= 1'b0;
            ldReg <= 1'b0;
            if (btnEdge[2]) begin
                ldReg   <= 1'b1;
                cur     <= IDLE;
                divider <= 4'd0;
            end else begin
                case (cur)
                    IDLE: begin
                        if (goUp) begin
                            cur     <= INC;
                            divider <= 4'd0;
                        end else if (goDown) begin
                            cur     <= DEC;
                            divider <= 4'd0;
                        end
                    end
                    INC: begin
                        if (goDown) begin
                            cur     <= DEC;
                            divider <= 4'd0;
                        end else if (stepTick) begin
                            divider <= 4'd0;
                            if (cnt.ycoord < YMaxV) begin
                                upReg <= 1'b1;
                            end else begin
`ifdef VLINE_BOUNCE_EN
                                cur <= DEC;
`else
                                cur <= IDLE;
`endif
                            end
                        end else if (frame) begin
                            divider <= divider + 4'd1;
                        end
                    end
                    DEC: begin
                        if (goUp) begin
                            cur     <= INC;
                            divider <= 4'd0;
                        end else if (stepTick) begin
                            divider <= 4'd0;
                            if (cnt.ycoord > YMinV) begin
                                dwReg <= 1'b1;
                            end else begin
`ifdef VLINE_BOUNCE_EN
                                cur <= INC;
`else
                                cur <= IDLE;
`endif
                            end
                        end else if (frame) begin
                            divider <= divider + 4'd1;
                        end
                    end
                    default: begin
                        cur     <= IDLE;
                        divider <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Self-checking bench for vline_motion_ctrl: directed scenarios followed by
// randomized button/frame traffic, scored against a behavioural model of the
// controller and of the line counter it drives.
module tb_vline_motion_ctrl;

    localparam int YMin    = 18;
    localparam int YMax    = 487;
    localparam int Center  = 252;
    localparam int StepDiv = 2;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame = 1'b0;
    logic       btnU = 1'b0;
    logic       btnD = 1'b0;
    logic       btnC = 1'b0;
    logic [1:0] state;

    vline_motion_ctrl_if link();

    vline_motion_ctrl #(
        .Y_MIN(YMin),
        .Y_MAX(YMax),
        .CENTER(Center),
        .STEP_DIV(StepDiv)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame(frame),
        .btnU(btnU),
        .btnD(btnD),
        .btnC(btnC),
        .cnt(link),
        .state(state)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         pos = 0;
    int         drivenY = 0;
    int         dir = 0;
    int         ticks = 0;
    int         prevKind = 0;
    logic [1:0] expState = 2'b00;
    logic [2:0] hU = 3'b000;
    logic [2:0] hD = 3'b000;
    logic [2:0] hC = 3'b000;
    exp_t       sbq[$];

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic reportFail(input string name, input int got, input int req);
        errors++;
        $display("[TB] FAIL %s at cycle %0d: got=%0d required=%0d", name, cyc, got, req);
    endtask

    // Reference behaviour for one clock: buttons reach the controller as
    // rising edges two samples late, direction and frame count decide the
    // strobe, and the counter applies last cycle's strobe to the position
    task automatic modelCycle();
        logic eU;
        logic eD;
        logic eC;
        int   kind;
        exp_t e;
        cyc++;
        eU = hU[1] & ~hU[2];
        eD = hD[1] & ~hD[2];
        eC = hC[1] & ~hC[2];
        hU = {hU[1:0], btnU};
        hD = {hD[1:0], btnD};
        hC = {hC[1:0], btnC};
        kind = 0;
        if (eC) begin
            kind  = 3;
            dir   = 0;
            ticks = 0;
        end else if (eU && !eD && dir != 1) begin
            dir   = 1;
            ticks = 0;
        end else if (eD && !eU && dir != -1) begin
            dir   = -1;
            ticks = 0;
        end else if (frame && dir != 0) begin
            ticks++;
            if (ticks == StepDiv) begin
                ticks = 0;
                if (dir == 1 && drivenY < YMax) kind = 1;
                else if (dir == -1 && drivenY > YMin) kind = 2;
                else begin
`ifdef VLINE_BOUNCE_EN
                    dir = -dir;
`else
                    dir = 0;
`endif
                end
            end
        end
        case (prevKind)
            1: pos = pos + 1;
            2: pos = pos - 1;
            3: pos = Center;
            default: ;
        endcase
        prevKind = kind;
        expState = (dir == 1) ? 2'b01 : (dir == -1) ? 2'b10 : 2'b00;
        if (kind != 0) begin
            e.cyc  = cyc;
            e.kind = (kind == 1) ? 3'b001 : (kind == 2) ? 3'b010 : 3'b100;
            sbq.push_back(e);
        end
    endtask

    task automatic modelReset();
        dir      = 0;
        ticks    = 0;
        prevKind = 0;
        expState = 2'b00;
        hU       = 3'b000;
        hD       = 3'b000;
        hC       = 3'b000;
        sbq.delete();
    endtask

    // Model advances with the DUT and plays the counter chain on ycoord
    always @(posedge clk) begin
        if (reset) modelCycle();
        drivenY = pos;
        link.ycoord <= drivenY[15:0];
    end

    // Compare state every cycle and match each presented strobe against
    // the oldest expected one
    task automatic checkOutput();
        logic [2:0] got;
        exp_t       e;
        got = {link.LD, link.DW, link.UP};
        checks++;
        if (state !== expState) reportFail("state", int'(state), int'(expState));
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++;
            e = sbq.pop_front();
            reportFail("strobe_missing", 0, int'(e.kind));
        end
        if (got !== 3'b000) begin
            checks++;
            if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                reportFail("strobe_unexpected", int'(got), 0);
            end else begin
                e = sbq.pop_front();
                if (got !== e.kind) reportFail("strobe_kind", int'(got), int'(e.kind));
                if (e.kind[2]) begin
                    checks++;
                    if (link.ld_val !== 16'(Center)) reportFail("ld_val", int'(link.ld_val), Center);
                end
            end
        end
    endtask

    // Monitor samples away from the active edge
    always @(negedge clk) begin
        if (reset) checkOutput();
    end

    task automatic nextCycle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulseFrame();
        frame = 1'b1;
        nextCycle(1);
        frame = 1'b0;
    endtask

    // Press and release one button: 0=U, 1=D, 2=C
    task automatic applyStimulus(input int which);
        case (which)
            0: btnU = 1'b1;
            1: btnD = 1'b1;
            default: btnC = 1'b1;
        endcase
        nextCycle(5);
        btnU = 1'b0;
        btnD = 1'b0;
        btnC = 1'b0;
        nextCycle(1);
    endtask

    task automatic frames(input int n, input int gap);
        repeat (n) begin
            pulseFrame();
            nextCycle(gap);
        end
    endtask

    // Hard stop if the run never reaches its summary
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        pos = 0;
        nextCycle(3);
        checks++;
        if ({link.UP, link.DW, link.LD} !== 3'b000 || state !== 2'b00)
            reportFail("reset_outputs", int'({link.UP, link.DW, link.LD, state}), 0);
        reset = 1'b1;

        $display("[TB] idle frames");
        frames(10, 2);

        $display("[TB] increment from 100");
        pos = 100;
        applyStimulus(0);
        frames(6, 3);

        $display("[TB] decrement from 300 then recentre");
        applyStimulus(1);
        pos = 300;
        frames(3, 3);
        applyStimulus(2);
        frames(4, 3);

        $display("[TB] upper limit");
        pos = 484;
        applyStimulus(0);
        frames(16, 2);
        applyStimulus(2);

        $display("[TB] simultaneous up/down");
        nextCycle(3);
        btnU = 1'b1;
        btnD = 1'b1;
        nextCycle(5);
        btnU = 1'b0;
        btnD = 1'b0;
        frames(4, 2);

        $display("[TB] recentre colliding with a step");
        pos = 200;
        applyStimulus(0);
        pulseFrame();
        nextCycle(2);
        btnC = 1'b1;
        nextCycle(1);
        nextCycle(1);
        frame = 1'b1;
        nextCycle(1);
        frame = 1'b0;
        nextCycle(3);
        btnC = 1'b0;
        frames(4, 2);

        $display("[TB] out-of-range coordinates");
        pos = 500;
        applyStimulus(0);
        frames(6, 2);
        applyStimulus(2);
        nextCycle(2);
        pos = 10;
        applyStimulus(1);
        frames(6, 2);
        applyStimulus(2);

        $display("[TB] randomized traffic");
        pos = 470;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) btnU = ~btnU;
            if ($urandom_range(0, 15) == 0) btnD = ~btnD;
            if ($urandom_range(0, 39) == 0) btnC = ~btnC;
            frame = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) pos = int'($urandom_range(0, 520));
            nextCycle(1);
        end
        btnU = 1'b0;
        btnD = 1'b0;
        btnC = 1'b0;
        frame = 1'b0;
        nextCycle(6);

        $display("[TB] reset during a strobe");
        applyStimulus(2);
        nextCycle(3);
        pos = 100;
        applyStimulus(0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            frame = ~frame;
            nextCycle(1);
            if (link.UP === 1'b1) begin
                seen = 1'b1;
                frame = 1'b0;
                reset = 1'b0;
                #1;
                checks++;
                if ({link.UP, link.DW, link.LD} !== 3'b000 || state !== 2'b00)
                    reportFail("reset_mid_strobe", int'({link.UP, link.DW, link.LD, state}), 0);
                modelReset();
            end
        end
        frame = 1'b0;
        if (!seen) begin
            checks++;
            reportFail("strobe_wait_timeout", 0, 1);
        end
        nextCycle(2);
        reset = 1'b1;
        frames(4, 2);

        nextCycle(6);
        checks++;
        if (sbq.size() != 0) reportFail("scoreboard_drain", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
